nios2_ocimem_arbiter: RTL and testbench



---
 rtl/nios2_ocimem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_arbiter.sv
// Arbiter sharing the on-chip debug RAM between the CPU slave port and the
// JTAG monitor; a pending JTAG access can be passed over at most JTAG_MAX_WAIT times.
module nios2_ocimem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int JTAG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int SW = (JTAG_MAX_WAIT < 1) ? 1 : $clog2(JTAG_MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(JTAG_MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RD  = 2'd1,
    ST_JTAG_RD = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic              pending_q, pending_d;
  logic              jwrite_q,  jwrite_d;
  logic [31:0]       jdata_q,   jdata_d;
  logic [ADDR_W-1:0] jaddr_q,   jaddr_d;
  logic [SW-1:0]     starve_q,  starve_d;
  logic [31:0]       mondreg_q, mondreg_d;
  logic              ready_q,   ready_d;
  logic              error_q,   error_d;
  logic [ADDR_W-1:0] raddr_q,   raddr_d;

  logic cpu_req;
  logic in_idle;
  logic jtag_grant;
  logic cpu_grant;
  logic cpu_rd_grant;
  logic cpu_wr_grant;
  logic cpu_rd_done;
  logic jtag_done;
  logic jdo_unused;

  assign jdo_unused = ^jdo[36:32];

  // Grants are suppressed while reset is held so no RAM write can escape.
  assign cpu_req      = av_read | av_write;
  assign in_idle      = reset_n & (state_q == ST_IDLE);
  assign jtag_grant   = in_idle & pending_q & (~cpu_req | (starve_q == STARVE_MAX));
  assign cpu_grant    = in_idle & cpu_req & ~jtag_grant;
  assign cpu_rd_grant = cpu_grant & av_read;
  assign cpu_wr_grant = cpu_grant & ~av_read;
  assign cpu_rd_done  = reset_n & (state_q == ST_CPU_RD) & av_read;
  assign jtag_done    = (jtag_grant & jwrite_q) | (state_q == ST_JTAG_RD);

  assign ram_we         = cpu_wr_grant | (jtag_grant & jwrite_q);
  assign ram_addr       = jtag_grant ? jaddr_q : (cpu_grant ? av_address : raddr_q);
  assign ram_wdata      = jtag_grant ? jdata_q : av_writedata;
  assign av_readdata    = (reset_n && state_q == ST_CPU_RD) ? ram_rdata : 32'h0;
  assign av_waitrequest = cpu_req & ~(cpu_wr_grant | cpu_rd_done);

  assign MonDReg       = mondreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    jwrite_d  = jwrite_q;
    jdata_d   = jdata_q;
    jaddr_d   = jaddr_q;
    starve_d  = starve_q;
    mondreg_d = mondreg_q;
    ready_d   = ready_q;
    error_d   = error_q;
    raddr_d   = raddr_q;

    case (state_q)
      ST_IDLE: begin
        if (jtag_grant) begin
          starve_d = '0;
          raddr_d  = jaddr_q;
          if (!jwrite_q) begin
            state_d = ST_JTAG_RD;
          end
        end else if (cpu_grant) begin
          raddr_d = av_address;
          if (cpu_rd_grant) begin
            state_d = ST_CPU_RD;
          end
          if (pending_q && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      ST_CPU_RD: begin
        state_d = ST_IDLE;
      end
      ST_JTAG_RD: begin
        state_d   = ST_IDLE;
        mondreg_d = ram_rdata;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion only happens while pending is set, so it never collides
    // with an accepted strobe below (those require pending clear).
    if (jtag_done) begin
      pending_d = 1'b0;
      ready_d   = 1'b1;
      jaddr_d   = jaddr_q + ADDR_W'(1);
    end

    if (take_action_ocimem_b) begin
      if (pending_q) begin
        error_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        jwrite_d  = jdo[37];
        jdata_d   = jdo[31:0];
        ready_d   = 1'b0;
      end
    end

    if (take_action_ocimem_a) begin
      if (pending_q) begin
        error_d = 1'b1;
      end else begin
        jaddr_d = jdo[ADDR_W-1:0];
        error_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      jwrite_q  <= 1'b0;
      jdata_q   <= '0;
      jaddr_q   <= '0;
      starve_q  <= '0;
      mondreg_q <= '0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
      raddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      jwrite_q  <= jwrite_d;
      jdata_q   <= jdata_d;
      jaddr_q   <= jaddr_d;
      starve_q  <= starve_d;
      mondreg_q <= mondreg_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      raddr_q   <= raddr_d;
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter: directed vectors, corner-case
// sequences and a random transaction stream against a memory-level model.
module tb_nios2_ocimem_arbiter;
  localparam int ADDR_W = 8;
  localparam int MAXW   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_a;
  logic        take_b;
  logic [37:0] jdo;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios2_ocimem_arbiter #(.ADDR_W(ADDR_W), .JTAG_MAX_WAIT(MAXW)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .jdo                  (jdo),
    .av_address           (av_address),
    .av_read              (av_read),
    .av_write             (av_write),
    .av_writedata         (av_writedata),
    .av_readdata          (av_readdata),
    .av_waitrequest       (av_waitrequest),
    .ram_addr             (ram_addr),
    .ram_we               (ram_we),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  always #5 clk = ~clk;

  // Debug RAM attached to the arbiter: registered read, one cycle latency.
  bit [31:0] ram [256];
  int        we_count = 0;
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      we_count      <= we_count + 1;
    end
    ram_rdata <= ram[ram_addr];
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_wait;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  bit   [31:0] mem_m [256];
  logic [7:0]  ja_m;
  logic [7:0]  aseen;
  logic [31:0] mon;
  logic [7:0]  ra;
  logic [31:0] rdat;
  logic        seen;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          grants;
  int          cyc;
  int          we0;
  int          op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // All tasks start just after a falling edge and return just after one.
  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    av_write = 1'b1; av_address = a; av_writedata = d;
    #1;
    chk1("cpu_wr_wait", av_waitrequest, 1'b0);
    chk1("cpu_wr_we", ram_we, 1'b1);
    chk("cpu_wr_addr", 32'(ram_addr), 32'(a));
    @(negedge clk);
    av_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp);
    av_read = 1'b1; av_address = a;
    #1;
    chk1("cpu_rd_wait_first", av_waitrequest, 1'b1);
    chk("cpu_rd_addr", 32'(ram_addr), 32'(a));
    @(negedge clk);
    #1;
    chk1("cpu_rd_wait_done", av_waitrequest, 1'b0);
    chk("cpu_rd_data", av_readdata, exp);
    @(negedge clk);
    av_read = 1'b0;
  endtask

  task automatic jtag_load(input logic [7:0] a);
    take_a = 1'b1; jdo = {30'h0, a};
    @(negedge clk);
    take_a = 1'b0;
  endtask

  task automatic jtag_access(input logic w, input logic [31:0] d, input logic la,
                             output logic [7:0] a_seen, output logic [31:0] mon_o);
    take_b = 1'b1; take_a = la; jdo = {w, 5'b0, d};
    @(negedge clk);
    take_b = 1'b0; take_a = 1'b0;
    #1;
    a_seen = ram_addr;
    chk1("jtag_grant_we", ram_we, w);
    chk1("jtag_busy", monitor_ready, 1'b0);
    @(negedge clk);
    if (!w) begin
      #1;
      chk1("jtag_rd_busy", monitor_ready, 1'b0);
      @(negedge clk);
    end
    #1;
    chk1("jtag_ready", monitor_ready, 1'b1);
    mon_o = MonDReg;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; take_a = 1'b0; take_b = 1'b0; jdo = '0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;

    vecs[0] = '{1'b0, 1'b1, 8'h05, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 8'h05, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 32'hA5A5_5A5A, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 32'h0,         1'b1, 1'b0, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 1'b0, 8'h06, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 8'h07, 32'h0,         1'b0, 1'b0, 32'h0};

    // Reset state, with a CPU request present during reset.
    repeat (2) @(negedge clk);
    av_read = 1'b1;
    #1;
    chk1("reset_ready", monitor_ready, 1'b1);
    chk1("reset_error", monitor_error, 1'b0);
    chk("reset_mondreg", MonDReg, 32'h0);
    chk1("reset_we", ram_we, 1'b0);
    chk("reset_rdata", av_readdata, 32'h0);
    chk1("reset_wait", av_waitrequest, 1'b1);
    @(negedge clk);
    av_read = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    ja_m = 8'h00;

    // CPU vectors, issued back to back.
    for (int i = 0; i < 6; i++) begin
      av_read = vecs[i].rd; av_write = vecs[i].wr;
      av_address = vecs[i].addr; av_writedata = vecs[i].wdata;
      #1;
      chk1("vec_wait", av_waitrequest, vecs[i].exp_wait);
      chk1("vec_we", ram_we, vecs[i].exp_we);
      if (vecs[i].rd || vecs[i].wr) chk("vec_addr", 32'(ram_addr), 32'(vecs[i].addr));
      else chk("vec_idle_rdata", av_readdata, 32'h0);
      @(negedge clk);
      if (vecs[i].rd) begin
        #1;
        chk1("vec_rd_wait", av_waitrequest, 1'b0);
        chk("vec_rd_data", av_readdata, vecs[i].exp_rdata);
        @(negedge clk);
      end
      if (vecs[i].wr) mem_m[vecs[i].addr] = vecs[i].wdata;
      av_read = 1'b0; av_write = 1'b0;
    end

    // JTAG write, read-after-increment, reload and read back.
    jtag_load(8'h10); ja_m = 8'h10;
    jtag_access(1'b1, 32'hDEAD_BEEF, 1'b0, aseen, mon);
    chk("j_wr_addr", 32'(aseen), 32'h10);
    mem_m[8'h10] = 32'hDEAD_BEEF; ja_m = 8'h11;
    jtag_access(1'b0, 32'h0, 1'b0, aseen, mon);
    chk("j_rd_addr_next", 32'(aseen), 32'h11);
    chk("j_rd_mon_unchanged", mon, 32'h0);
    jtag_load(8'h10); ja_m = 8'h10;
    jtag_access(1'b0, 32'h0, 1'b0, aseen, mon);
    chk("j_rd_addr_reload", 32'(aseen), 32'h10);
    chk("j_rd_mon_data", mon, 32'hDEAD_BEEF);
    jtag_access(1'b0, 32'h0, 1'b0, aseen, mon);
    chk("j_addr_after_rd", 32'(aseen), 32'h11);
    ja_m = 8'h12;

    // Second strobe while pending is dropped; only one RAM write happens.
    we0 = we_count;
    take_b = 1'b1; jdo = {1'b1, 5'b0, 32'h0BAD_F00D};
    @(negedge clk);
    jdo = {1'b1, 5'b0, 32'h1111_1111};
    @(negedge clk);
    take_b = 1'b0;
    #1;
    chk1("drop_error_set", monitor_error, 1'b1);
    chk1("drop_ready", monitor_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("drop_one_write", 32'(we_count - we0), 32'd1);
    chk("drop_write_data", ram[8'h12], 32'h0BAD_F00D);
    mem_m[8'h12] = 32'h0BAD_F00D;
    jtag_load(8'h30); ja_m = 8'h30;
    #1;
    chk1("load_clears_error", monitor_error, 1'b0);
    @(negedge clk);

    // Address wrap and simultaneous load+access.
    jtag_load(8'hFF); ja_m = 8'hFF;
    jtag_access(1'b0, 32'h0, 1'b0, aseen, mon);
    chk("wrap_rd_addr", 32'(aseen), 32'hFF);
    chk("wrap_rd_mon", mon, mem_m[8'hFF]);
    jtag_access(1'b1, 32'hCAFE_0000, 1'b0, aseen, mon);
    chk("wrap_to_zero", 32'(aseen), 32'h00);
    mem_m[8'h00] = 32'hCAFE_0000;
    jtag_access(1'b1, 32'h0000_0020, 1'b1, aseen, mon);
    chk("simul_ab_addr", 32'(aseen), 32'h20);
    mem_m[8'h20] = 32'h0000_0020;

    // Starvation bound: JTAG wins after MAXW CPU grants, twice in a row.
    cpu_write(8'h40, 32'h4040_4040); mem_m[8'h40] = 32'h4040_4040;
    jtag_load(8'h40); ja_m = 8'h40;
    for (int r = 0; r < 2; r++) begin
      av_read = 1'b1; av_address = 8'h05;
      take_b = 1'b1; jdo = '0;
      grants = 0; seen = 1'b0; cyc = 0;
      @(negedge clk);
      take_b = 1'b0;
      while (!seen && cyc < 40) begin
        #1;
        if (av_waitrequest && ram_addr == ja_m) seen = 1'b1;
        else if (av_waitrequest && ram_addr == 8'h05) grants++;
        @(negedge clk);
        cyc++;
      end
      chk1("starve_jtag_seen", seen, 1'b1);
      chk("starve_cpu_grants", 32'(grants), 32'(MAXW));
      @(negedge clk);
      #1;
      chk1("starve_ready", monitor_ready, 1'b1);
      chk("starve_mon", MonDReg, mem_m[ja_m]);
      av_read = 1'b0;
      ja_m = ja_m + 8'd1;
      @(negedge clk);
      @(negedge clk);
    end

    // Reset in the JTAG_RD cycle discards the read.
    jtag_load(8'h10);
    take_b = 1'b1; jdo = '0;
    @(negedge clk);
    take_b = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk1("rst_mid_we", ram_we, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_mid_mon", MonDReg, 32'h0);
    chk1("rst_mid_ready", monitor_ready, 1'b1);
    chk1("rst_mid_error", monitor_error, 1'b0);
    we0 = we_count;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk1("rst_recover_we", ram_we, 1'b0);
      chk1("rst_recover_ready", monitor_ready, 1'b1);
    end
    chk("rst_recover_wecnt", 32'(we_count - we0), 32'd0);
    @(negedge clk);
    ja_m = 8'h00;
    jtag_access(1'b0, 32'h0, 1'b0, aseen, mon);
    chk("rst_jaddr_zero", 32'(aseen), 32'h00);
    chk("rst_after_mon", mon, mem_m[8'h00]);
    ja_m = 8'h01;

    // Random serial transactions against the memory-level model.
    for (int t = 0; t < 150; t++) begin
      op   = int'($urandom_range(0, 4));
      ra   = 8'($urandom);
      rdat = $urandom;
      $display("txn %0d op=%0d addr=%h data=%h", t, op, ra, rdat);
      case (op)
        0: begin cpu_write(ra, rdat); mem_m[ra] = rdat; end
        1: cpu_read(ra, mem_m[ra]);
        2: begin jtag_load(ra); ja_m = ra; end
        3: begin
          jtag_access(1'b1, rdat, 1'b0, aseen, mon);
          chk("rand_jwr_addr", 32'(aseen), 32'(ja_m));
          mem_m[ja_m] = rdat;
          ja_m = ja_m + 8'd1;
        end
        default: begin
          jtag_access(1'b0, 32'h0, 1'b0, aseen, mon);
          chk("rand_jrd_addr", 32'(aseen), 32'(ja_m));
          chk("rand_jrd_mon", mon, mem_m[ja_m]);
          ja_m = ja_m + 8'd1;
        end
      endcase
    end
    #1;
    chk1("rand_no_error", monitor_error, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
